// File: rtl/bt656_pkg.sv
// Shared types and constants for the BT.656 line unpacker: preamble FSM states,
// TRS byte values, XY bit positions and the decoded timing-code struct.
package bt656_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_P3   = 2'd3
    } trs_state_t;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int XY_BIT_ONE = 7;
    localparam int XY_BIT_F   = 6;
    localparam int XY_BIT_V   = 5;
    localparam int XY_BIT_H   = 4;

    typedef struct packed {
        logic f;
        logic v;
        logic h;
        logic valid;
    } trs_t;

    function automatic trs_t xy_decode(input logic [7:0] xy);
        trs_t t;
        t.f     = xy[XY_BIT_F];
        t.v     = xy[XY_BIT_V];
        t.h     = xy[XY_BIT_H];
        t.valid = xy[XY_BIT_ONE];
        return t;
    endfunction

    // Hamming-style protection bits P3..P0 carried in the low nibble of XY.
    function automatic logic xy_prot_ok(input logic [7:0] xy);
        logic f, v, h;
        f = xy[XY_BIT_F];
        v = xy[XY_BIT_V];
        h = xy[XY_BIT_H];
        return (xy[3] == (v ^ h)) && (xy[2] == (f ^ h)) &&
               (xy[1] == (f ^ v)) && (xy[0] == (f ^ v ^ h));
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Preamble (FF 00 00) detector and XY decoder. Optional protection-bit check and
// error counter are built when BT656_PROT_CHECK_EN is defined.
//
// state  | meaning
// S_DATA | ordinary data bytes; FF starts a preamble
// S_P1   | FF seen
// S_P2   | FF 00 seen
// S_P3   | FF 00 00 seen; current byte is XY
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_bt_data,
    input  logic       i_bt_valid,
    output logic       o_trs_strobe,
    output trs_t       o_trs,
    output logic       o_data_byte
`ifdef BT656_PROT_CHECK_EN
    ,
    output logic [7:0] o_prot_err_cnt
`endif
);

    trs_state_t r_state;
    trs_t       w_dec;
    logic       w_xy_cycle;
    logic       w_accept;

    assign w_dec      = xy_decode(i_bt_data);
    assign w_xy_cycle = i_bt_valid && (r_state == S_P3);

`ifdef BT656_PROT_CHECK_EN
    logic [7:0] r_prot_err_cnt;

    assign w_accept       = w_dec.valid && xy_prot_ok(i_bt_data);
    assign o_prot_err_cnt = r_prot_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prot_err_cnt <= 8'd0;
        end else if (w_xy_cycle && w_dec.valid && !xy_prot_ok(i_bt_data)
                     && (r_prot_err_cnt != 8'hFF)) begin
            r_prot_err_cnt <= r_prot_err_cnt + 8'd1;
        end
    end
`else
    assign w_accept = w_dec.valid;
`endif

    assign o_trs_strobe = w_xy_cycle && w_accept;
    assign o_trs        = w_dec;
    assign o_data_byte  = i_bt_valid && (r_state == S_DATA) && (i_bt_data != TRS_FF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_DATA;
        end else if (i_bt_valid) begin
            case (r_state)
                S_DATA: if (i_bt_data == TRS_FF) r_state <= S_P1;
                S_P1: begin
                    if (i_bt_data == TRS_00)      r_state <= S_P2;
                    else if (i_bt_data == TRS_FF) r_state <= S_P1;
                    else                          r_state <= S_DATA;
                end
                S_P2: begin
                    if (i_bt_data == TRS_00)      r_state <= S_P3;
                    else if (i_bt_data == TRS_FF) r_state <= S_P1;
                    else                          r_state <= S_DATA;
                end
                S_P3:    r_state <= S_DATA;
                default: r_state <= S_DATA;
            endcase
        end
    end

endmodule

// File: rtl/bt656_line_unpacker.sv
// BT.656 byte stream to cropped {Y,C} pixel words with field/frame tracking.
// Define BT656_PROT_CHECK_EN to enable XY protection checking and prot_err_cnt.
module bt656_line_unpacker
    import bt656_pkg::*;
#(
    parameter int ACTIVE_PIX = 720,
    parameter int CROP_START = 40,
    parameter int OUT_PIX    = 640,
    parameter int LINE_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        bt_data,
    input  logic              bt_valid,
    input  logic              pix_full,
    output logic [15:0]       pix_data,
    output logic              pix_wr,
    output logic              field,
    output logic              frame_done,
    output logic              buffer_select,
    output logic [LINE_W-1:0] line_cnt,
    output logic              locked,
    output logic              overflow
`ifdef BT656_PROT_CHECK_EN
    ,
    output logic [7:0]        prot_err_cnt
`endif
);

    localparam int BYTE_MAX = 2 * ACTIVE_PIX;
    localparam int BC_W     = $clog2(BYTE_MAX + 1);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(BYTE_MAX);
    localparam logic [BC_W-1:0] CROP_LO = BC_W'(CROP_START);
    localparam logic [BC_W-1:0] CROP_HI = BC_W'(CROP_START + OUT_PIX);

    logic              w_trs_strobe;
    trs_t              w_trs;
    logic              w_data_byte;
    logic              w_trs_ev;
    logic [BC_W-1:0]   w_pix_idx;
    logic              w_in_crop;

    logic [BC_W-1:0]   r_byte_cnt;
    logic              r_in_line;
    logic              r_prev_v;
    logic [7:0]        r_c;
    logic [15:0]       r_pix_data;
    logic              r_pix_wr;
    logic              r_field;
    logic              r_frame_done;
    logic              r_buffer_select;
    logic [LINE_W-1:0] r_line_cnt;
    logic              r_locked;
    logic              r_overflow;

    bt656_trs_detect u_trs_detect (
        .clk          (clk),
        .reset        (reset),
        .i_bt_data    (bt_data),
        .i_bt_valid   (bt_valid),
        .o_trs_strobe (w_trs_strobe),
        .o_trs        (w_trs),
        .o_data_byte  (w_data_byte)
`ifdef BT656_PROT_CHECK_EN
        ,
        .o_prot_err_cnt (prot_err_cnt)
`endif
    );

    assign w_trs_ev  = w_trs_strobe && w_trs.valid;
    assign w_pix_idx = r_byte_cnt >> 1;
    assign w_in_crop = (w_pix_idx >= CROP_LO) && (w_pix_idx < CROP_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt      <= '0;
            r_in_line       <= 1'b0;
            r_prev_v        <= 1'b0;
            r_c             <= 8'd0;
            r_pix_data      <= 16'd0;
            r_pix_wr        <= 1'b0;
            r_field         <= 1'b0;
            r_frame_done    <= 1'b0;
            r_buffer_select <= 1'b0;
            r_line_cnt      <= '0;
            r_locked        <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_pix_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_trs_ev) begin
                r_field  <= w_trs.f;
                r_prev_v <= w_trs.v;
                if (!w_trs.h) begin
                    if (!w_trs.v) begin
                        r_byte_cnt <= '0;
                        r_in_line  <= 1'b1;
                        r_locked   <= 1'b1;
                    end else begin
                        r_in_line <= 1'b0;
                    end
                end else begin
                    r_in_line <= 1'b0;
                    // End-of-field clear takes priority over counting the closing line.
                    if (w_trs.v && !r_prev_v) begin
                        r_line_cnt <= '0;
                        if (w_trs.f) begin
                            r_frame_done    <= 1'b1;
                            r_buffer_select <= ~r_buffer_select;
                        end
                    end else if (r_in_line) begin
                        r_line_cnt <= r_line_cnt + LINE_W'(1);
                    end
                end
            end else if (w_data_byte && r_in_line && (r_byte_cnt != BC_SAT)) begin
                r_byte_cnt <= r_byte_cnt + BC_W'(1);
                if (!r_byte_cnt[0]) begin
                    r_c <= bt_data;
                end else if (w_in_crop) begin
                    if (pix_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pix_wr   <= 1'b1;
                        r_pix_data <= {bt_data, r_c};
                    end
                end
            end
        end
    end

    assign pix_data      = r_pix_data;
    assign pix_wr        = r_pix_wr;
    assign field         = r_field;
    assign frame_done    = r_frame_done;
    assign buffer_select = r_buffer_select;
    assign line_cnt      = r_line_cnt;
    assign locked        = r_locked;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_bt656_line_unpacker.sv
// Directed bench for bt656_line_unpacker with a scoreboard of expected pixel words.
module tb_bt656_line_unpacker;

    localparam int CROP_LO = 40;
    localparam int CROP_HI = 680;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bt_data;
    logic        bt_valid;
    logic        pix_full;
    logic [15:0] pix_data;
    logic        pix_wr;
    logic        field;
    logic        frame_done;
    logic        buffer_select;
    logic [9:0]  line_cnt;
    logic        locked;
    logic        overflow;
`ifdef BT656_PROT_CHECK_EN
    logic [7:0]  prot_err_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_total = 0;
    int          fd_total = 0;
    bit          gapped = 1'b0;
    logic [15:0] sb[$];

    bt656_line_unpacker dut (
        .clk           (clk),
        .reset         (reset),
        .bt_data       (bt_data),
        .bt_valid      (bt_valid),
        .pix_full      (pix_full),
        .pix_data      (pix_data),
        .pix_wr        (pix_wr),
        .field         (field),
        .frame_done    (frame_done),
        .buffer_select (buffer_select),
        .line_cnt      (line_cnt),
        .locked        (locked),
        .overflow      (overflow)
`ifdef BT656_PROT_CHECK_EN
        ,
        .prot_err_cnt  (prot_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pix_wr === 1'b1) begin
            wr_total++;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed word %h expected no write", pix_data);
            end
            if (sb.size() > 0) check("pix_data", 32'(pix_data), 32'(sb.pop_front()));
        end
        if (frame_done === 1'b1) fd_total++;
    endtask

    task automatic send(input logic [7:0] b);
        bt_data  = b;
        bt_valid = 1'b1;
        tick();
        bt_valid = 1'b0;
        if (gapped) begin
            bt_data = 8'hFF;
            tick();
        end
    endtask

    task automatic send_trs(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
    endtask

    task automatic send_pixels(input int first, input int last, input int full_lo,
                               input int full_hi, input bit exp_en);
        logic [7:0] c, y;
        for (int p = first; p <= last; p++) begin
            c = (p % 2 == 0) ? 8'h10 : 8'h30;
            y = (p % 2 == 0) ? 8'h20 : 8'h40;
            send(c);
            pix_full = (p >= full_lo) && (p <= full_hi);
            if (exp_en && p >= CROP_LO && p < CROP_HI && !pix_full) sb.push_back({y, c});
            send(y);
            pix_full = 1'b0;
        end
    endtask

    task automatic send_line(input int npix, input int full_lo, input int full_hi);
        send_trs(8'h80);
        send_pixels(0, npix - 1, full_lo, full_hi, 1'b1);
        send_trs(8'h9D);
    endtask

    initial begin
        int base;
        int fd_base;
        reset    = 1'b1;
        bt_data  = 8'h00;
        bt_valid = 1'b0;
        pix_full = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_pix_wr", 32'(pix_wr), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_flags", {field, frame_done, buffer_select, locked, overflow}, 0);
        check("rst_line_cnt", 32'(line_cnt), 0);

`ifdef BT656_PROT_CHECK_EN
        send_trs(8'h81);
        check("prot_err_cnt", 32'(prot_err_cnt), 1);
        check("prot_bad_not_locked", 32'(locked), 0);
`endif

        // Unlocked stream and a blanking SAV must not produce writes.
        base = wr_total;
        for (int i = 0; i < 16; i++) send(8'(8'h10 + 8'h10 * (i % 4)));
        send_trs(8'hAB);
        check("prelock_locked", 32'(locked), 0);
        check("prelock_writes", 32'(wr_total - base), 0);

        send_trs(8'h80);
        check("sav_locked", 32'(locked), 1);
        send_pixels(0, 719, -1, -1, 1'b1);
        send_trs(8'h9D);
        check("line1_writes", 32'(wr_total - base), 640);
        check("line1_line_cnt", 32'(line_cnt), 1);
        check("line1_overflow", 32'(overflow), 0);

        base = wr_total;
        send_line(720, 100, 109);
        check("ovf_writes", 32'(wr_total - base), 630);
        check("ovf_flag", 32'(overflow), 1);
        base = wr_total;
        send_line(720, -1, -1);
        check("ovf_next_writes", 32'(wr_total - base), 640);
        check("ovf_sticky", 32'(overflow), 1);
        check("line3_line_cnt", 32'(line_cnt), 3);

        fd_base = fd_total;
        send_trs(8'hF1);
        check("f1_frame_done", 32'(fd_total - fd_base), 1);
        check("f1_buffer_select", 32'(buffer_select), 1);
        check("f1_line_cnt", 32'(line_cnt), 0);
        check("f1_field", 32'(field), 1);
        tick();
        check("f1_pulse_width", 32'(fd_total - fd_base), 1);

        send_line(720, -1, -1);
        check("f0_line_cnt_pre", 32'(line_cnt), 1);
        fd_base = fd_total;
        send_trs(8'hB6);
        check("f0_no_frame_done", 32'(fd_total - fd_base), 0);
        check("f0_line_cnt", 32'(line_cnt), 0);
        check("f0_buffer_select", 32'(buffer_select), 1);
        check("f0_field", 32'(field), 0);

        gapped = 1'b1;
        base = wr_total;
        send_line(720, -1, -1);
        gapped = 1'b0;
        check("gap_writes", 32'(wr_total - base), 640);
        check("gap_line_cnt", 32'(line_cnt), 1);

        base = wr_total;
        send_line(100, -1, -1);
        check("trunc_writes", 32'(wr_total - base), 60);
        check("trunc_line_cnt", 32'(line_cnt), 2);

        base = wr_total;
        send_line(724, -1, -1);
        check("sat_writes", 32'(wr_total - base), 640);
        check("sat_line_cnt", 32'(line_cnt), 3);

        // Reset in the middle of a line (after byte 500).
        send_trs(8'h80);
        send_pixels(0, 249, -1, -1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pix_wr", 32'(pix_wr), 0);
        check("mid_rst_flags", {field, frame_done, buffer_select, locked, overflow}, 0);
        check("mid_rst_line_cnt", 32'(line_cnt), 0);
        check("mid_rst_pix_data", 32'(pix_data), 0);
        base = wr_total;
        send_pixels(250, 719, -1, -1, 1'b0);
        send_trs(8'h9D);
        check("post_rst_writes", 32'(wr_total - base), 0);
        check("post_rst_locked", 32'(locked), 0);
        send_line(720, -1, -1);
        check("recover_writes", 32'(wr_total - base), 640);
        check("recover_locked", 32'(locked), 1);
        check("recover_line_cnt", 32'(line_cnt), 1);

        repeat (2) tick();
        check("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
